// File: rtl/gpp_control_unit.sv
// gpp_control_unit: instruction sequencer for the 16-bit GPP.
// Fetch/latch/decode/execute FSM with PC, return register, flags, retire count.
module gpp_control_unit #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [15:0]      imem_rdata,
    output logic [15:0]      line_data,
    input  logic [1:0]       instr_type,
    input  logic [5:0]       opcode,
    input  logic [1:0]       reg_x_or_y,
    input  logic [PC_W-1:0]  address_to_go,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ready,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [3:0]       alu_flags,
    output logic             reg_x_we,
    output logic             reg_y_we,
    output logic [3:0]       flags,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_LATCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_ALU_WAIT,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_STR  = 6'd2;
    localparam logic [5:0] OP_BRZ  = 6'd3;
    localparam logic [5:0] OP_BRN  = 6'd4;
    localparam logic [5:0] OP_BRC  = 6'd5;
    localparam logic [5:0] OP_BRV  = 6'd6;
    localparam logic [5:0] OP_BRA  = 6'd7;
    localparam logic [5:0] OP_CALL = 6'd8;
    localparam logic [5:0] OP_RET  = 6'd9;

    localparam logic [1:0] T_MEM = 2'b01;
    localparam logic [1:0] T_BR  = 2'b10;
    localparam logic [1:0] T_ALU = 2'b11;

    state_t            r_state;
    logic [PC_W-1:0]   r_ret;

    logic [PC_W-1:0]   w_pc_inc;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_taken;
    logic [PC_W-1:0]   w_br_pc;
    logic              w_sel_x;
    logic              w_sel_y;

    // Wrapping increments; pc rolls 511 -> 0 at the default width.
    assign w_pc_inc  = pc + {{(PC_W-1){1'b0}}, 1'b1};
    assign w_cnt_inc = instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    assign imem_addr = pc;

    // Only the 01/10 encodings name a register; 00/11 write nothing.
    assign w_sel_x = (reg_x_or_y == 2'b01);
    assign w_sel_y = (reg_x_or_y == 2'b10);

    // Branch condition from latched flags {Z,N,C,V}.
    always_comb begin
        w_taken = 1'b0;
        case (opcode)
            OP_BRZ:  w_taken = flags[3];
            OP_BRN:  w_taken = flags[2];
            OP_BRC:  w_taken = flags[1];
            OP_BRV:  w_taken = flags[0];
            OP_BRA:  w_taken = 1'b1;
            OP_CALL: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    // Next pc for a branch: RET uses the saved return address.
    always_comb begin
        w_br_pc = w_pc_inc;
        if (opcode == OP_RET) begin
            w_br_pc = r_ret;
        end else if (w_taken) begin
            w_br_pc = address_to_go;
        end
    end

    // Sequencing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_ret       <= '0;
            pc          <= '0;
            line_data   <= '0;
            flags       <= '0;
            instr_count <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            alu_start   <= 1'b0;
            reg_x_we    <= 1'b0;
            reg_y_we    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            reg_x_we  <= 1'b0;
            reg_y_we  <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    r_state <= S_LATCH;
                end
                S_LATCH: begin
                    line_data <= imem_rdata;
                    if (imem_rdata[15:10] == 6'd0) begin
                        halted  <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    case (instr_type)
                        T_MEM: begin
                            mem_req <= 1'b1;
                            mem_we  <= (opcode == OP_STR);
                            r_state <= S_MEM;
                        end
                        T_BR: begin
                            if (opcode == OP_CALL) begin
                                r_ret <= w_pc_inc;
                            end
                            pc          <= w_br_pc;
                            instr_count <= w_cnt_inc;
                            r_state     <= S_FETCH;
                        end
                        T_ALU: begin
                            alu_start <= 1'b1;
                            r_state   <= S_ALU_WAIT;
                        end
                        default: begin
                            pc          <= w_pc_inc;
                            instr_count <= w_cnt_inc;
                            r_state     <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_we) begin
                            reg_x_we <= w_sel_x;
                            reg_y_we <= w_sel_y;
                        end
                        pc          <= w_pc_inc;
                        instr_count <= w_cnt_inc;
                        r_state     <= S_FETCH;
                    end
                end
                S_ALU_WAIT: begin
                    if (alu_done) begin
                        flags       <= alu_flags;
                        reg_x_we    <= w_sel_x;
                        reg_y_we    <= w_sel_y;
                        pc          <= w_pc_inc;
                        instr_count <= w_cnt_inc;
                        r_state     <= S_FETCH;
                    end
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpp_control_unit.sv
// tb_gpp_control_unit: directed bench with imem, decoder and
// memory/ALU responder models around gpp_control_unit.
module tb_gpp_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic [15:0] line_data;
    logic [1:0]  instr_type = '0;
    logic [5:0]  opcode = '0;
    logic [1:0]  reg_x_or_y = '0;
    logic [8:0]  address_to_go = '0;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ready;
    logic        alu_start;
    logic        alu_done;
    logic [3:0]  alu_flags = '0;
    logic        reg_x_we;
    logic        reg_y_we;
    logic [3:0]  flags;
    logic [8:0]  pc;
    logic        halted;
    logic [15:0] instr_count;

    logic [15:0] imem [512];
    logic        r_mem_ready = 1'b0;
    logic        r_alu_done = 1'b0;
    logic        stray_mem = 1'b0;
    logic        stray_alu = 1'b0;
    int          mem_delay = 1;
    int          alu_delay = 1;
    int          mcnt = 0;
    int          acnt = 0;
    int          cnt_x = 0;
    int          cnt_y = 0;
    int          cnt_req = 0;
    int          cnt_we = 0;
    int          cnt_as = 0;
    int          checks = 0;
    int          failures = 0;
    int          exp_cnt = 0;

    assign mem_ready = r_mem_ready | stray_mem;
    assign alu_done  = r_alu_done | stray_alu;

    gpp_control_unit #(.PC_W(9), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .line_data(line_data),
        .instr_type(instr_type),
        .opcode(opcode),
        .reg_x_or_y(reg_x_or_y),
        .address_to_go(address_to_go),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_ready(mem_ready),
        .alu_start(alu_start),
        .alu_done(alu_done),
        .alu_flags(alu_flags),
        .reg_x_we(reg_x_we),
        .reg_y_we(reg_y_we),
        .flags(flags),
        .pc(pc),
        .halted(halted),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory.
    always @(posedge clk) imem_rdata <= imem[imem_addr];

    function automatic logic [1:0] dec_type(input logic [5:0] op);
        if (op == 6'd0) return 2'b00;
        if (op <= 6'd2) return 2'b01;
        if (op <= 6'd9) return 2'b10;
        return 2'b11;
    endfunction

    // Registered decoder model.
    always @(posedge clk) begin
        if (rst) begin
            instr_type    <= '0;
            opcode        <= '0;
            reg_x_or_y    <= '0;
            address_to_go <= '0;
        end else begin
            instr_type    <= dec_type(line_data[15:10]);
            opcode        <= line_data[15:10];
            address_to_go <= line_data[8:0];
            if (line_data[15:10] >= 6'd10)
                reg_x_or_y <= line_data[9] ? 2'b10 : 2'b01;
            else
                reg_x_or_y <= line_data[9:8];
        end
    end

    // Data-memory responder: ready on the mem_delay-th request cycle.
    always @(negedge clk) begin
        if (mem_req) mcnt = mcnt + 1;
        else mcnt = 0;
        r_mem_ready = mem_req && (mcnt == mem_delay);
    end

    // ALU responder: done on the alu_delay-th cycle from alu_start.
    always @(negedge clk) begin
        if (alu_start) acnt = 1;
        else if (acnt != 0) acnt = acnt + 1;
        r_alu_done = (acnt != 0) && (acnt == alu_delay);
        if (r_alu_done) acnt = 0;
    end

    // Pulse and level counters.
    always @(negedge clk) begin
        cnt_x   = cnt_x + int'(reg_x_we);
        cnt_y   = cnt_y + int'(reg_y_we);
        cnt_req = cnt_req + int'(mem_req);
        cnt_we  = cnt_we + int'(mem_req && mem_we);
        cnt_as  = cnt_as + int'(alu_start);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic exec(input string tag, input logic [8:0] addr,
                        input logic [15:0] word, input logic [3:0] af,
                        input int ad, input int md, input int ecyc,
                        input logic [8:0] epc, input int ex, input int ey,
                        input int ereq, input int ewe, input int eas,
                        input logic [3:0] ef);
        int x0, y0, rq0, we0, as0, n;
        logic [15:0] c0;
        chk({tag, "_pc0"}, 32'(pc), 32'(addr));
        imem[addr] = word;
        alu_flags  = af;
        alu_delay  = ad;
        mem_delay  = md;
        x0  = cnt_x;
        y0  = cnt_y;
        rq0 = cnt_req;
        we0 = cnt_we;
        as0 = cnt_as;
        c0  = instr_count;
        n   = 0;
        while (instr_count == c0 && n < 40) begin
            step();
            n = n + 1;
        end
        exp_cnt = exp_cnt + 1;
        chk({tag, "_cyc"}, 32'(n), 32'(ecyc));
        chk({tag, "_pc"}, 32'(pc), 32'(epc));
        chk({tag, "_cnt"}, 32'(instr_count), 32'(exp_cnt));
        chk({tag, "_xwe"}, 32'(cnt_x - x0), 32'(ex));
        chk({tag, "_ywe"}, 32'(cnt_y - y0), 32'(ey));
        chk({tag, "_req"}, 32'(cnt_req - rq0), 32'(ereq));
        chk({tag, "_we"}, 32'(cnt_we - we0), 32'(ewe));
        chk({tag, "_as"}, 32'(cnt_as - as0), 32'(eas));
        chk({tag, "_flg"}, 32'(flags), 32'(ef));
    endtask

    initial begin
        int x0, y0, as0, n;
        for (int i = 0; i < 512; i++) imem[i] = 16'h0000;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_cnt", 32'(instr_count), 32'h0);
        chk("rst_line", 32'(line_data), 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_halt", 32'(halted), 32'h0);
        chk("rst_req", 32'({mem_req, mem_we, alu_start, reg_x_we, reg_y_we}), 32'h0);
        rst = 1'b0;

        exec("alu_x", 9'h000, 16'h2803, 4'b0001, 1, 1, 5, 9'h001, 1, 0, 0, 0, 1, 4'b0001);
        exec("ldr_y", 9'h001, 16'h0605, 4'b0001, 1, 3, 7, 9'h002, 0, 1, 3, 0, 0, 4'b0001);
        exec("call", 9'h002, 16'h2014, 4'b0000, 1, 1, 4, 9'h014, 0, 0, 0, 0, 0, 4'b0001);
        exec("str", 9'h014, 16'h0805, 4'b0000, 1, 1, 5, 9'h015, 0, 0, 1, 1, 0, 4'b0001);
        exec("ldr_nosel", 9'h015, 16'h0405, 4'b0000, 1, 2, 6, 9'h016, 0, 0, 2, 0, 0, 4'b0001);
        exec("alu_y", 9'h016, 16'h2A03, 4'b1000, 3, 1, 7, 9'h017, 0, 1, 0, 0, 1, 4'b1000);
        exec("ret", 9'h017, 16'h2400, 4'b0000, 1, 1, 4, 9'h003, 0, 0, 0, 0, 0, 4'b1000);
        exec("bra", 9'h003, 16'h1C05, 4'b0000, 1, 1, 4, 9'h005, 0, 0, 0, 0, 0, 4'b1000);
        exec("brz_t", 9'h005, 16'h0C40, 4'b0000, 1, 1, 4, 9'h040, 0, 0, 0, 0, 0, 4'b1000);
        exec("alu_z0", 9'h040, 16'h2803, 4'b0000, 2, 1, 6, 9'h041, 1, 0, 0, 0, 1, 4'b0000);
        exec("brz_nt", 9'h041, 16'h0C40, 4'b1111, 1, 1, 4, 9'h042, 0, 0, 0, 0, 0, 4'b0000);
        exec("alu_c", 9'h042, 16'h2803, 4'b0010, 1, 1, 5, 9'h043, 1, 0, 0, 0, 1, 4'b0010);
        exec("brc_t", 9'h043, 16'h15FF, 4'b0000, 1, 1, 4, 9'h1FF, 0, 0, 0, 0, 0, 4'b0010);
        exec("call_wrap", 9'h1FF, 16'h2010, 4'b0000, 1, 1, 4, 9'h010, 0, 0, 0, 0, 0, 4'b0010);
        exec("ret_zero", 9'h010, 16'h2400, 4'b0000, 1, 1, 4, 9'h000, 0, 0, 0, 0, 0, 4'b0010);

        imem[0] = 16'h0000;
        chk("halt_fetch", 32'(halted), 32'h0);
        step();
        chk("halt_latch", 32'(halted), 32'h0);
        step();
        chk("halt_on", 32'(halted), 32'h1);
        x0  = cnt_x;
        y0  = cnt_y;
        as0 = cnt_as;
        for (int i = 0; i < 6; i++) begin
            stray_mem = 1'b1;
            stray_alu = (i % 2) == 0;
            step();
        end
        stray_mem = 1'b0;
        stray_alu = 1'b0;
        step();
        chk("halt_stay", 32'(halted), 32'h1);
        chk("halt_pc", 32'(pc), 32'h0);
        chk("halt_cnt", 32'(instr_count), 32'(exp_cnt));
        chk("halt_req", 32'(mem_req), 32'h0);
        chk("halt_we", 32'((cnt_x - x0) + (cnt_y - y0) + (cnt_as - as0)), 32'h0);
        chk("halt_flg", 32'(flags), 32'h2);

        rst = 1'b1;
        step();
        chk("rst2_halt", 32'(halted), 32'h0);
        chk("rst2_pc", 32'(pc), 32'h0);
        chk("rst2_cnt", 32'(instr_count), 32'h0);
        rst = 1'b0;

        imem[0]   = 16'h0605;
        mem_delay = 1000;
        n = 0;
        while (!mem_req && n < 20) begin
            step();
            n = n + 1;
        end
        chk("mrst_seen", 32'(mem_req), 32'h1);
        chk("mrst_lat", 32'(n), 32'h4);
        step();
        x0 = cnt_x;
        y0 = cnt_y;
        rst = 1'b1;
        step();
        chk("mrst_req", 32'(mem_req), 32'h0);
        chk("mrst_cnt", 32'(instr_count), 32'h0);
        chk("mrst_pc", 32'(pc), 32'h0);
        chk("mrst_line", 32'(line_data), 32'h0);
        step();
        chk("mrst_we", 32'((cnt_x - x0) + (cnt_y - y0)), 32'h0);
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpp_control_unit.md
# gpp_control_unit

Sequencing controller for the 16-bit general-purpose processor. It fetches instruction words from a synchronous instruction memory and holds each in an instruction register that feeds the instruction decoder. Using the decoder's registered `type`/`opcode`/`reg_x_or_y`/`address_to_go` outputs, it drives the data-memory handshake, ALU start and register write enables. It owns the program counter, the return-address register, the latched ALU flags and a retired-instruction counter.

## Interface
Parameters:
- `PC_W`, 9, program-counter / address width.
- `CNT_W`, 16, retired-instruction counter width.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  PC_W  instruction-memory address; equals `pc`.
- `imem_rdata`  in  16  instruction word; valid the cycle after `imem_addr` is presented.
- `line_data`  out  16  instruction register; drives the decoder input.
- `type`  in  2  decoder type: 01 load/store, 10 branch, 11 ALU.
- `opcode`  in  6  decoder opcode.
- `reg_x_or_y`  in  2  decoder register select: 01 X, 10 Y.
- `address_to_go`  in  PC_W  decoder branch target.
- `mem_req`  out  1  data-memory request; level, held until `mem_ready`.
- `mem_we`  out  1  1 = store (STR), 0 = load (LDR); valid while `mem_req` is high.
- `mem_ready`  in  1  data-memory completion.
- `alu_start`  out  1  one-cycle ALU launch pulse.
- `alu_done`  in  1  ALU result valid.
- `alu_flags`  in  4  {Z,N,C,V} from the ALU; sampled with `alu_done`.
- `reg_x_we`, `reg_y_we`  out  1  one-cycle register write enables.
- `flags`  out  4  latched {Z,N,C,V}.
- `pc`  out  PC_W  program counter.
- `halted`  out  1  high in HALT.
- `instr_count`  out  CNT_W  retired instructions; wraps modulo 2^CNT_W.

## Operation
- Reset: state FETCH. `pc`, `line_data`, `flags`, return register, `instr_count`, `mem_req`, `mem_we`, `alu_start`, `reg_*_we` and `halted` are all 0.
- FETCH: present `imem_addr = pc` -> LATCH.
- LATCH: `line_data <= imem_rdata`. If `imem_rdata[15:10] == 0` -> HALT; otherwise -> DECODE.
- DECODE: wait one cycle while the decoder registers `line_data` -> EXEC.
- EXEC, dispatched on `type`:
  - 01 -> assert `mem_req`, with `mem_we = (opcode == 2)` -> MEM.
  - 10 -> resolve the branch, update `pc`, retire -> FETCH.
  - 11 -> pulse `alu_start` -> ALU_WAIT.
  - 00 -> NOP: `pc+1`, retire -> FETCH.
- MEM: hold `mem_req`/`mem_we`. On `mem_ready`:
  - drop `mem_req`;
  - for a load, pulse the write enable selected by `reg_x_or_y`;
  - `pc+1`, retire -> FETCH.
- ALU_WAIT: on `alu_done`:
  - `flags <= alu_flags`;
  - pulse the selected `reg_*_we`;
  - `pc+1`, retire -> FETCH.
- HALT: absorbing; `halted = 1`. Only `rst` exits it. A HALT instruction does not increment `instr_count`.
- Branch opcodes (taken: `pc <= address_to_go`; not taken: `pc <= pc+1`):
  - 3 BRZ (Z), 4 BRN (N), 5 BRC (C), 6 BRV (V), 7 BRA (always).
  - 8 CALL: return register <= `pc+1`, then `pc <= address_to_go`.
  - 9 RET: `pc <=` return register.
- Branches read `flags` only. Stores and branches never modify `flags`.
- `pc` arithmetic is modulo 2^PC_W: 511+1 = 0. A CALL at 511 saves 0.
- `reg_x_or_y` values 00 or 11 in a write context: no write enable asserted; the instruction still retires.

## Timing
- Branch/NOP: 4 cycles (FETCH, LATCH, DECODE, EXEC).
- Load/store: 4 + N cycles, where N ≥ 1 is the number of MEM cycles up to and including the `mem_ready` cycle.
- ALU: 4 + M cycles, where M ≥ 1 is the number of ALU_WAIT cycles. `alu_done` is honoured only in ALU_WAIT.
- `alu_done` in EXEC or any other state is ignored. `mem_ready` outside MEM is ignored.
- `reg_*_we` and `alu_start` are high for exactly one cycle per instruction.
- `instr_count` increments on the same edge that returns to FETCH.
- `rst` mid-instruction (for example during MEM): all outputs reach reset values on that edge. `mem_req` is low in the next cycle and no write enable fires.

## Test plan
- Reset, then imem[0] = 0x2803 (opcode 10, X, imm 3), `alu_done` one cycle after `alu_start`, `alu_flags` = 0001 -> `reg_x_we` pulses once, `flags` = 0001, `pc` = 1, `instr_count` = 1, 5 cycles total.
- LDR Y (0x0605) with `mem_ready` delayed 3 cycles -> `mem_req` high for 3 cycles with `mem_we` = 0, then `reg_y_we` pulses once; STR (0x0805) -> `mem_we` = 1 and no write enable.
- `flags` Z = 1, BRZ 0x0C40 at `pc` 5 -> `pc` = 0x040. `flags` Z = 0 -> `pc` = 6. Each branch takes 4 cycles.
- CALL 0x2014 at `pc` 2 -> `pc` = 0x014; later RET -> `pc` = 3. CALL at `pc` 511 -> return register = 0.
- imem[k] = 0x0000 -> `halted` = 1 from the cycle after LATCH, `pc` frozen, `instr_count` unchanged; stray `mem_ready`/`alu_done` pulses have no effect; `rst` -> FETCH with `pc` = 0.
- Assert `rst` during MEM wait -> `mem_req` = 0 the next cycle, no write enable, `instr_count` = 0.
